ami_sdram_bridge_array: RTL and testbench

- Parametrised successor to the per-channel AMI-to-SimpleDRAM converter.
- Instantiates NUM_CHANNELS buffered bridge engines between the AMI memory interconnect's channel side and SimpleDRAM controllers.
- Each engine adds:
  - a request FIFO of configurable depth;
  - a read-outstanding limiter with a metadata FIFO that restores AMI response size;
  - a skid-registered response path;
  - a per-channel drain/flush FSM, used for app reconfiguration.

---
 rtl/ami_sdram_bridge_array_pkg.sv | 58 +++++
 rtl/ami_sdram_bridge_channel.sv | 142 ++++++++++++++
 rtl/ami_sdram_bridge_array.sv | 52 +++++
 tb/tb_ami_sdram_bridge_array.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ami_sdram_bridge_array_pkg.sv
// Shared AMI / SimpleDRAM bundle types and bridge defaults.
// AMI_BRIDGE_PERF_EN adds the per-channel BridgePerf export.
package ami_sdram_bridge_array_pkg;

  localparam int AMI_NUM_CHANNELS = 2;
  localparam int AMI_ADDR_W = 64;
  localparam int AMI_DATA_W = 64;
  localparam int AMI_SIZE_W = 32;
  localparam int AMI_BRIDGE_REQ_DEPTH = 8;
  localparam int AMI_BRIDGE_MAX_OUTSTANDING = 16;

  typedef struct packed {
    logic                  valid;
    logic                  isWrite;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } AMIRequest;

  typedef struct packed {
    logic                  valid;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } AMIResponse;

  typedef struct packed {
    logic                  valid;
    logic                  isWrite;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
  } MemReq;

  typedef struct packed {
    logic                  valid;
    logic [AMI_DATA_W-1:0] data;
  } MemResp;

  typedef struct packed {
    logic                  isWrite;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } ReqEntry;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } BridgeState;

  typedef struct packed {
    logic [31:0] reads_issued;
    logic [31:0] writes_issued;
    logic [31:0] stall_cycles;
    logic        unexpected_resp;
  } BridgePerf;

endpackage

// File: rtl/ami_sdram_bridge_channel.sv
// One buffered AMI-to-SimpleDRAM engine: request FIFO, read limiter,
// response register, drain FSM. AMI_BRIDGE_PERF_EN adds perf_out.
module ami_sdram_bridge_channel
  import ami_sdram_bridge_array_pkg::*;
#(
  parameter int REQ_DEPTH       = AMI_BRIDGE_REQ_DEPTH,
  parameter int MAX_OUTSTANDING = AMI_BRIDGE_MAX_OUTSTANDING
) (
  input  logic       clk,
  input  logic       rst,
  input  AMIRequest  ami_req_in,
  output logic       ami_req_grant_out,
  output AMIResponse ami_resp_out,
  input  logic       ami_resp_grant_in,
  output MemReq      sdram_req_out,
  input  logic       sdram_req_grant_in,
  input  MemResp     sdram_resp_in,
  output logic       sdram_resp_grant_out,
  input  logic       flush_in,
  output logic       flush_done_out
`ifdef AMI_BRIDGE_PERF_EN
  ,
  output BridgePerf  perf_out
`endif
);

  localparam int AW  = $clog2(REQ_DEPTH);
  localparam int MAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;

  ReqEntry               req_mem [REQ_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [AMI_SIZE_W-1:0] meta_mem [2**MAW];
  logic [MAW:0]          mw_ptr, mr_ptr;
  logic [OW-1:0]         outstanding;
  BridgeState            state_q, state_d;
  ReqEntry               head;
  logic fifo_full, fifo_empty, meta_full, issue_ok;
  logic push, pop, rd_pop, resp_hit, idle;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign meta_full  = ((mw_ptr - mr_ptr) == (MAW+1)'(MAX_OUTSTANDING));
  assign head       = req_mem[rd_ptr[AW-1:0]];
  assign issue_ok   = head.isWrite |
                      ((outstanding < OW'(MAX_OUTSTANDING)) & !meta_full);

  assign ami_req_grant_out = ami_req_in.valid & !fifo_full & (state_q == RUN);
  assign push   = ami_req_grant_out;
  assign pop    = sdram_req_out.valid & sdram_req_grant_in;
  assign rd_pop = pop & !head.isWrite;

  assign sdram_resp_grant_out = sdram_resp_in.valid &
                                (!ami_resp_out.valid | ami_resp_grant_in);
  // A grant with nothing outstanding is an orphan: consumed, not forwarded.
  assign resp_hit = sdram_resp_grant_out & (outstanding != '0);

  assign idle = fifo_empty & (outstanding == '0) & !ami_resp_out.valid;
  assign flush_done_out = (state_q == DONE);

  always_comb begin
    sdram_req_out = '0;
    if (!fifo_empty && issue_ok) begin
      sdram_req_out.valid   = 1'b1;
      sdram_req_out.isWrite = head.isWrite;
      sdram_req_out.addr    = head.addr;
      sdram_req_out.data    = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      req_mem[wr_ptr[AW-1:0]] <= '{isWrite: ami_req_in.isWrite,
                                   addr:    ami_req_in.addr,
                                   data:    ami_req_in.data,
                                   size:    ami_req_in.size};
    end
    if (rd_pop) begin
      meta_mem[mw_ptr[MAW-1:0]] <= head.size;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mw_ptr       <= '0;
      mr_ptr       <= '0;
      outstanding  <= '0;
      ami_resp_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (rd_pop) mw_ptr <= mw_ptr + 1'b1;
      if (resp_hit) mr_ptr <= mr_ptr + 1'b1;
      if (rd_pop && !resp_hit) outstanding <= outstanding + 1'b1;
      else if (!rd_pop && resp_hit) outstanding <= outstanding - 1'b1;
      if (resp_hit) begin
        ami_resp_out <= '{valid: 1'b1,
                          data:  sdram_resp_in.data,
                          size:  meta_mem[mr_ptr[MAW-1:0]]};
      end else if (ami_resp_grant_in) begin
        ami_resp_out.valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_in) state_d = DRAIN;
      DRAIN:   if (!flush_in) state_d = RUN;
               else if (idle) state_d = DONE;
      DONE:    if (!flush_in) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

`ifdef AMI_BRIDGE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_out <= '0;
    end else begin
      if (rd_pop && perf_out.reads_issued != '1)
        perf_out.reads_issued <= perf_out.reads_issued + 1'b1;
      if (pop && !rd_pop && perf_out.writes_issued != '1)
        perf_out.writes_issued <= perf_out.writes_issued + 1'b1;
      if (!fifo_empty && !issue_ok && perf_out.stall_cycles != '1)
        perf_out.stall_cycles <= perf_out.stall_cycles + 1'b1;
      if (sdram_resp_grant_out && !resp_hit)
        perf_out.unexpected_resp <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ami_sdram_bridge_array.sv
// NUM_CHANNELS independent AMI-to-SimpleDRAM bridge engines.
// AMI_BRIDGE_PERF_EN exports per-channel perf_out counters.
module ami_sdram_bridge_array
  import ami_sdram_bridge_array_pkg::*;
#(
  parameter int NUM_CHANNELS    = AMI_NUM_CHANNELS,
  parameter int REQ_DEPTH       = AMI_BRIDGE_REQ_DEPTH,
  parameter int MAX_OUTSTANDING = AMI_BRIDGE_MAX_OUTSTANDING
) (
  input  logic                    clk,
  input  logic                    rst,
  input  AMIRequest               ami_req_in [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] ami_req_grant_out,
  output AMIResponse              ami_resp_out [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] ami_resp_grant_in,
  output MemReq                   sdram_req_out [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] sdram_req_grant_in,
  input  MemResp                  sdram_resp_in [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] sdram_resp_grant_out,
  input  logic [NUM_CHANNELS-1:0] flush_in,
  output logic [NUM_CHANNELS-1:0] flush_done_out
`ifdef AMI_BRIDGE_PERF_EN
  ,
  output BridgePerf               perf_out [NUM_CHANNELS]
`endif
);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    ami_sdram_bridge_channel #(
      .REQ_DEPTH       (REQ_DEPTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_ch (
      .clk                  (clk),
      .rst                  (rst),
      .ami_req_in           (ami_req_in[g]),
      .ami_req_grant_out    (ami_req_grant_out[g]),
      .ami_resp_out         (ami_resp_out[g]),
      .ami_resp_grant_in    (ami_resp_grant_in[g]),
      .sdram_req_out        (sdram_req_out[g]),
      .sdram_req_grant_in   (sdram_req_grant_in[g]),
      .sdram_resp_in        (sdram_resp_in[g]),
      .sdram_resp_grant_out (sdram_resp_grant_out[g]),
      .flush_in             (flush_in[g]),
      .flush_done_out       (flush_done_out[g])
`ifdef AMI_BRIDGE_PERF_EN
      ,
      .perf_out             (perf_out[g])
`endif
    );
  end

endmodule

// File: tb/tb_ami_sdram_bridge_array.sv
// Directed bench for ami_sdram_bridge_array: vector table plus
// hand-written limiter, backpressure, stall, flush and reset sequences.
module tb_ami_sdram_bridge_array;
  import ami_sdram_bridge_array_pkg::*;

  localparam int NCH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  AMIRequest  ami_req_in [NCH];
  logic [NCH-1:0] ami_req_grant_out;
  AMIResponse ami_resp_out [NCH];
  logic [NCH-1:0] ami_resp_grant_in;
  MemReq      sdram_req_out [NCH];
  logic [NCH-1:0] sdram_req_grant_in;
  MemResp     sdram_resp_in [NCH];
  logic [NCH-1:0] sdram_resp_grant_out;
  logic [NCH-1:0] flush_in;
  logic [NCH-1:0] flush_done_out;
`ifdef AMI_BRIDGE_PERF_EN
  BridgePerf  perf_out [NCH];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ami_sdram_bridge_array #(
    .NUM_CHANNELS    (NCH),
    .REQ_DEPTH       (8),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ami_req_in           (ami_req_in),
    .ami_req_grant_out    (ami_req_grant_out),
    .ami_resp_out         (ami_resp_out),
    .ami_resp_grant_in    (ami_resp_grant_in),
    .sdram_req_out        (sdram_req_out),
    .sdram_req_grant_in   (sdram_req_grant_in),
    .sdram_resp_in        (sdram_resp_in),
    .sdram_resp_grant_out (sdram_resp_grant_out),
    .flush_in             (flush_in),
    .flush_done_out       (flush_done_out)
`ifdef AMI_BRIDGE_PERF_EN
    ,
    .perf_out             (perf_out)
`endif
  );

  typedef struct {
    logic rv; logic rw; logic [63:0] ra; logic [63:0] rd; logic [31:0] rs;
    logic sg; logic pv; logic [63:0] pd; logic ag;
  } in_t;

  typedef struct {
    logic rg; logic sv; logic sw; logic [63:0] sa; logic [63:0] sd;
    logic pg; logic av; logic [63:0] ad; logic [31:0] as;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < NCH; c++) begin
      ami_req_in[c]    = '0;
      sdram_resp_in[c] = '0;
    end
    ami_resp_grant_in  = '0;
    sdram_req_grant_in = '0;
    flush_in           = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic req0(input logic v, input logic w, input logic [63:0] a,
                      input logic [63:0] d, input logic [31:0] s);
    ami_req_in[0] = '{valid: v, isWrite: w, addr: a, data: d, size: s};
  endtask

  in_t  vin [11];
  exp_t vex [11];
  int sent, issued, iss1, order_err, ch0_err;

  initial begin
    vin[0]  = '{1, 0, 64'h40, 0, 32'd64, 0, 0, 0, 0};
    vex[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vin[1]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    vex[1]  = '{0, 1, 0, 64'h40, 0, 0, 0, 0, 0};
    vin[2]  = '{0, 0, 0, 0, 0, 0, 1, 64'hABCD, 0};
    vex[2]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    vin[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vex[3]  = '{0, 0, 0, 0, 0, 0, 1, 64'hABCD, 32'd64};
    vin[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vex[4]  = '{0, 0, 0, 0, 0, 0, 1, 64'hABCD, 32'd64};
    vin[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    vex[5]  = '{0, 0, 0, 0, 0, 0, 1, 64'hABCD, 32'd64};
    vin[6]  = '{1, 1, 64'h80, 64'h1234, 0, 0, 0, 0, 0};
    vex[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vin[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    vex[7]  = '{0, 1, 1, 64'h80, 64'h1234, 0, 0, 0, 0};
    vin[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vex[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vin[9]  = '{0, 0, 0, 0, 0, 0, 1, 64'hDEAD, 0};
    vex[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    vin[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vex[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    do_reset();
    check("rst_req_grant", 64'(ami_req_grant_out), 0);
    check("rst_sreq_valid0", 64'(sdram_req_out[0].valid), 0);
    check("rst_aresp_valid0", 64'(ami_resp_out[0].valid), 0);
    check("rst_flush_done", 64'(flush_done_out), 0);

    // single read, write pass-through, orphan response
    for (int i = 0; i < 11; i++) begin
      req0(vin[i].rv, vin[i].rw, vin[i].ra, vin[i].rd, vin[i].rs);
      sdram_req_grant_in[0] = vin[i].sg;
      sdram_resp_in[0] = '{valid: vin[i].pv, data: vin[i].pd};
      ami_resp_grant_in[0] = vin[i].ag;
      #1;
      check($sformatf("v%0d_rg", i), 64'(ami_req_grant_out[0]), 64'(vex[i].rg));
      check($sformatf("v%0d_sv", i), 64'(sdram_req_out[0].valid), 64'(vex[i].sv));
      check($sformatf("v%0d_sw", i), 64'(sdram_req_out[0].isWrite), 64'(vex[i].sw));
      check($sformatf("v%0d_sa", i), sdram_req_out[0].addr, vex[i].sa);
      check($sformatf("v%0d_sd", i), sdram_req_out[0].data, vex[i].sd);
      check($sformatf("v%0d_pg", i), 64'(sdram_resp_grant_out[0]), 64'(vex[i].pg));
      check($sformatf("v%0d_av", i), 64'(ami_resp_out[0].valid), 64'(vex[i].av));
      if (vex[i].av) begin
        check($sformatf("v%0d_ad", i), ami_resp_out[0].data, vex[i].ad);
        check($sformatf("v%0d_as", i), 64'(ami_resp_out[0].size), 64'(vex[i].as));
      end
      check($sformatf("v%0d_fd", i), 64'(flush_done_out[0]), 0);
      tick();
    end

    // outstanding limit of 4 with 6 reads offered
    do_reset();
    sent = 0;
    issued = 0;
    sdram_req_grant_in[0] = 1'b1;
    ami_resp_grant_in[0]  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req0(sent < 6, 1'b0, 64'h100 + 64'(sent) * 64'h40, 0, 32'd64);
      #1;
      if (ami_req_grant_out[0]) sent++;
      if (sdram_req_out[0].valid) issued++;
      tick();
    end
    check("lim_granted", 64'(sent), 6);
    check("lim_issued", 64'(issued), 4);
    check("lim_blocked", 64'(sdram_req_out[0].valid), 0);
    sdram_resp_in[0] = '{valid: 1'b1, data: 64'h11};
    #1;
    check("lim_resp_grant", 64'(sdram_resp_grant_out[0]), 1);
    tick();
    sdram_resp_in[0] = '0;
    check("lim_resp_data", ami_resp_out[0].data, 64'h11);
    check("lim_5th_valid", 64'(sdram_req_out[0].valid), 1);
    check("lim_5th_addr", sdram_req_out[0].addr, 64'h200);
    tick();
    check("lim_6th_blocked", 64'(sdram_req_out[0].valid), 0);

    // backpressure: 10 writes into 8-deep FIFO
    do_reset();
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      req0(sent < 10, 1'b1, 64'h1000 + 64'(sent), 64'(sent), 0);
      #1;
      if (ami_req_grant_out[0]) sent++;
      tick();
    end
    check("bp_granted", 64'(sent), 8);
    check("bp_full_grant", 64'(ami_req_grant_out[0]), 0);
    check("bp_head_addr", sdram_req_out[0].addr, 64'h1000);
    check("bp_head_write", 64'(sdram_req_out[0].isWrite), 1);
    sdram_req_grant_in[0] = 1'b1;
    #1;
    check("bp_pop_cycle_grant", 64'(ami_req_grant_out[0]), 0);
    tick();
    check("bp_after_pop_grant", 64'(ami_req_grant_out[0]), 1);
    check("bp_next_addr", sdram_req_out[0].addr, 64'h1001);

    // response stall: three reads, consumer holds off
    do_reset();
    sdram_req_grant_in[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req0(1'b1, 1'b0, 64'h2000 + 64'(k) * 64'h40, 0, 32'd32 << k);
      tick();
    end
    req0(0, 0, 0, 0, 0);
    tick();
    tick();
    sdram_req_grant_in[0] = 1'b0;
    sdram_resp_in[0] = '{valid: 1'b1, data: 64'hD0};
    #1;
    check("st_first_grant", 64'(sdram_resp_grant_out[0]), 1);
    tick();
    sdram_resp_in[0] = '{valid: 1'b1, data: 64'hD1};
    #1;
    check("st_hold_grant", 64'(sdram_resp_grant_out[0]), 0);
    check("st_d0_data", ami_resp_out[0].data, 64'hD0);
    check("st_d0_size", 64'(ami_resp_out[0].size), 32);
    tick();
    check("st_hold_grant2", 64'(sdram_resp_grant_out[0]), 0);
    check("st_d0_held", ami_resp_out[0].data, 64'hD0);
    ami_resp_grant_in[0] = 1'b1;
    #1;
    check("st_release_grant", 64'(sdram_resp_grant_out[0]), 1);
    tick();
    ami_resp_grant_in[0] = 1'b0;
    sdram_resp_in[0] = '{valid: 1'b1, data: 64'hD2};
    #1;
    check("st_d2_wait", 64'(sdram_resp_grant_out[0]), 0);
    check("st_d1_data", ami_resp_out[0].data, 64'hD1);
    check("st_d1_size", 64'(ami_resp_out[0].size), 64);
    tick();
    ami_resp_grant_in[0] = 1'b1;
    #1;
    check("st_d2_grant", 64'(sdram_resp_grant_out[0]), 1);
    tick();
    sdram_resp_in[0] = '0;
    check("st_d2_data", ami_resp_out[0].data, 64'hD2);
    check("st_d2_size", 64'(ami_resp_out[0].size), 128);
    tick();
    check("st_drained", 64'(ami_resp_out[0].valid), 0);

    // flush with two reads in flight
    do_reset();
    sdram_req_grant_in[0] = 1'b1;
    ami_resp_grant_in[0]  = 1'b1;
    req0(1'b1, 1'b0, 64'h3000, 0, 32'd64);
    tick();
    req0(1'b1, 1'b0, 64'h3040, 0, 32'd64);
    tick();
    req0(0, 0, 0, 0, 0);
    tick();
    sdram_req_grant_in[0] = 1'b0;
    flush_in[0] = 1'b1;
    tick();
    req0(1'b1, 1'b1, 64'h3100, 64'h5, 0);
    #1;
    check("fl_refuse", 64'(ami_req_grant_out[0]), 0);
    check("fl_not_done", 64'(flush_done_out[0]), 0);
    tick();
    sdram_resp_in[0] = '{valid: 1'b1, data: 64'hF1};
    tick();
    sdram_resp_in[0] = '{valid: 1'b1, data: 64'hF2};
    tick();
    sdram_resp_in[0] = '0;
    check("fl_last_resp", ami_resp_out[0].data, 64'hF2);
    check("fl_done_early", 64'(flush_done_out[0]), 0);
    tick();
    check("fl_done_consume", 64'(flush_done_out[0]), 0);
    tick();
    check("fl_done", 64'(flush_done_out[0]), 1);
    check("fl_done_refuse", 64'(ami_req_grant_out[0]), 0);
    flush_in[0] = 1'b0;
    tick();
    check("fl_run_done", 64'(flush_done_out[0]), 0);
    check("fl_run_accept", 64'(ami_req_grant_out[0]), 1);

    // channel isolation and mid-stream reset
    do_reset();
    req0(1'b1, 1'b1, 64'hAAAA, 64'h1, 0);
    tick();
    req0(0, 0, 0, 0, 0);
    sdram_req_grant_in[1] = 1'b1;
    sent = 0;
    iss1 = 0;
    order_err = 0;
    ch0_err = 0;
    for (int c = 0; c < 40 && iss1 < 16; c++) begin
      ami_req_in[1] = '{valid: sent < 16, isWrite: 1'b1,
                        addr: 64'h5000 + 64'(sent), data: 64'(sent), size: 0};
      #1;
      if (ami_req_grant_out[1]) sent++;
      if (sdram_req_out[1].valid) begin
        if (sdram_req_out[1].addr != 64'h5000 + 64'(iss1)) order_err++;
        iss1++;
      end
      if (sdram_req_out[0].valid !== 1'b1 ||
          sdram_req_out[0].addr !== 64'hAAAA) ch0_err++;
      tick();
    end
    check("iso_ch1_issued", 64'(iss1), 16);
    check("iso_ch1_order", 64'(order_err), 0);
    check("iso_ch0_stable", 64'(ch0_err), 0);
    check("iso_ch0_head", sdram_req_out[0].addr, 64'hAAAA);
    check("iso_ch1_no_resp", 64'(ami_resp_out[1].valid), 0);
    ami_req_in[1] = '{valid: 1'b1, isWrite: 1'b1, addr: 64'h6000,
                      data: 0, size: 0};
    tick();
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    check("mrst_grants", 64'(ami_req_grant_out), 0);
    check("mrst_sreq0", 64'(sdram_req_out[0] == '0), 1);
    check("mrst_sreq1", 64'(sdram_req_out[1] == '0), 1);
    check("mrst_aresp0", 64'(ami_resp_out[0] == '0), 1);
    check("mrst_aresp1", 64'(ami_resp_out[1] == '0), 1);
    check("mrst_resp_grant", 64'(sdram_resp_grant_out), 0);
    check("mrst_done", 64'(flush_done_out), 0);
    rst = 1'b0;
    sdram_resp_in[1] = '{valid: 1'b1, data: 64'hBAD};
    #1;
    check("late_resp_grant", 64'(sdram_resp_grant_out[1]), 1);
    tick();
    sdram_resp_in[1] = '0;
    check("late_resp_dropped", 64'(ami_resp_out[1].valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
